pipe_stall_ctrl: RTL
====================

# pipe_stall_ctrl

Pipeline hazard and multi-cycle scheduler for the 5-stage MIPS core. It drives the hold inputs of the PC register and the IF/ID register, inserts bubbles into ID/EX, and flushes IF/ID on taken branches. It also sequences the iterative mult/div unit: it issues the start pulse, tracks busy cycles and commits HI/LO. A saturating stall counter is provided for performance debug.

## Interface
Parameters:
- DIV_CYCLES, 32, mult/div latency in cycles; legal range 2..255
- CNT_W, 16, width of the stall performance counter

Ports:
- clk  in  1  pipeline clock, all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_muldiv  in  1  ID instruction is mult/multu/div/divu
- id_hilo_use  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- id_branch_taken  in  1  branch/jump in ID resolved taken
- ex_wreg  in  1  EX instruction writes the register file
- ex_m2reg  in  1  EX instruction is a load
- ex_rn  in  5  EX destination register
- pc_hold  out  1  hold the PC register; same sense as the PC register's load-dependency hold
- ifid_hold  out  1  hold the IF/ID register
- idex_bubble  out  1  load a NOP into ID/EX
- ifid_flush  out  1  clear IF/ID to a NOP on the next edge
- md_start  out  1  one-cycle start pulse to the mult/div unit
- md_busy  out  1  mult/div operation in flight
- hilo_we  out  1  one-cycle HI/LO write enable
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- load_use = ex_m2reg & ex_wreg & (ex_rn != 0) & ((id_use_rs & ex_rn == id_rs) | (id_use_rt & ex_rn == id_rt)).
- md_stall = (state == BUSY) & (id_hilo_use | id_muldiv).
- stall = load_use | md_stall. pc_hold, ifid_hold and idex_bubble all equal stall. These are combinational.
- ifid_flush = id_branch_taken & ~stall. Stall takes priority over flush: the branch re-resolves after the stall clears.
- State machine, states IDLE and BUSY, with a count register 8 bits wide:
  - IDLE: if id_muldiv & ~stall, then md_start = 1 (combinational), the next state is BUSY and count loads DIV_CYCLES-1.
  - BUSY: if count != 0, count decrements. If count == 0, hilo_we = 1 (combinational) and the next state is IDLE.
- md_busy = (state == BUSY).
- A muldiv that arrives in IDLE during a load_use stall does not issue. It issues in the first non-stalled cycle.
- stall_cnt increments on each edge where stall = 1. It saturates at all-ones and never wraps.

## Timing
- Reset, on the first edge with rst = 1: state = IDLE, count = 0, stall_cnt = 0.
- With rst high and no hazard inputs, every output is 0. The outputs are combinational, so they follow their inputs even during reset, except those gated by state.
- Reset mid-operation returns to IDLE at once. No hilo_we is produced for the aborted operation.
- Load-use stall lasts exactly 1 cycle. On the next edge the load moves to MEM, ex_* change, and the hazard clears.
- Mult/div issued in cycle T:
  - md_start is high in T.
  - md_busy is high in T+1 through T+DIV_CYCLES.
  - hilo_we is high in T+DIV_CYCLES.
  - The state is IDLE in T+DIV_CYCLES+1.
- An mfhi in ID at T+1 stalls for DIV_CYCLES cycles and proceeds at T+DIV_CYCLES+1.
- A back-to-back muldiv issues at T+DIV_CYCLES+1 at the earliest.
- Register file write-back forwarding for MEM/WB is outside this block. Only the EX-load hazard is detected here.

## Test plan
- Load-use: ex_m2reg=1, ex_wreg=1, ex_rn=8, id_rs=8, id_use_rs=1 -> pc_hold, ifid_hold and idex_bubble are 1 for one cycle; stall_cnt goes 0 -> 1. Repeat with ex_rn=0 -> no stall.
- Div + mfhi with DIV_CYCLES=4: id_muldiv at T -> md_start at T; md_busy at T+1..T+4; hilo_we only at T+4; mfhi at T+1 sees stall for 4 cycles; stall_cnt = 4.
- Branch during a load-use stall: id_branch_taken=1 together with load_use -> ifid_flush=0. The next cycle, with the hazard gone -> ifid_flush=1 and pc_hold=0.
- Muldiv coinciding with load_use in IDLE -> md_start=0 that cycle and md_start=1 the next cycle; hilo_we arrives DIV_CYCLES cycles after the actual issue.
- Reset at T+2 of a 32-cycle div -> at T+3 md_busy=0, and hilo_we is never asserted.
- CNT_W=4 with a constant stall for 20 cycles -> stall_cnt = 15 and holds there.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard detection and multi-cycle scheduler for the 5-stage
// MIPS core. Produces the PC / IF/ID hold, the ID/EX bubble and the IF/ID flush,
// sequences the iterative mult/div unit (start pulse, busy window, HI/LO commit)
// and keeps a saturating count of stalled cycles for performance debug.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 32,  // mult/div latency, 2..255
  parameter int CNT_W      = 16   // stall counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_muldiv,
  input  logic             id_hilo_use,
  input  logic             id_branch_taken,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rn,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             hilo_we,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Count loaded at issue; reaching zero marks the final busy cycle.
  localparam logic [7:0] COUNT_LOAD = 8'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] count_r;
  logic [7:0] count_nxt_s;

  logic load_use_s;
  logic md_stall_s;
  logic stall_s;
  logic md_start_s;
  logic hilo_we_s;

  // A load in EX whose destination feeds the ID instruction must wait one cycle;
  // $zero is never a real dependency.
  assign load_use_s = ex_m2reg & ex_wreg & (ex_rn != 5'd0) &
                      ((id_use_rs & (ex_rn == id_rs)) |
                       (id_use_rt & (ex_rn == id_rt)));

  // HI/LO readers/writers and a second mult/div wait while the unit is busy.
  assign md_stall_s = (state_r == BUSY) & (id_hilo_use | id_muldiv);
  assign stall_s    = load_use_s | md_stall_s;

  assign pc_hold     = stall_s;
  assign ifid_hold   = stall_s;
  assign idex_bubble = stall_s;
  // A stalled branch is re-resolved once the stall clears, so stall wins.
  assign ifid_flush  = id_branch_taken & ~stall_s;
  assign md_start    = md_start_s;
  assign hilo_we     = hilo_we_s;
  assign md_busy     = (state_r == BUSY);

  // State and busy-count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state and next-count logic of the mult/div sequencer.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    case (state_r)
      IDLE: begin
        if (md_start_s) begin
          state_nxt_s = BUSY;
          count_nxt_s = COUNT_LOAD;
        end else begin
          state_nxt_s = IDLE;
          count_nxt_s = count_r;
        end
      end
      BUSY: begin
        if (count_r != 8'd0) begin
          state_nxt_s = BUSY;
          count_nxt_s = count_r - 8'd1;
        end else begin
          state_nxt_s = IDLE;
          count_nxt_s = 8'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        count_nxt_s = 8'd0;
      end
    endcase
  end

  // Sequencer outputs: issue pulse in IDLE, HI/LO commit on the last busy cycle.
  always_comb begin
    md_start_s = 1'b0;
    hilo_we_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (id_muldiv & ~stall_s) begin
          md_start_s = 1'b1;
        end else begin
          md_start_s = 1'b0;
        end
      end
      BUSY: begin
        if (count_r == 8'd0) begin
          hilo_we_s = 1'b1;
        end else begin
          hilo_we_s = 1'b0;
        end
      end
      default: begin
        md_start_s = 1'b0;
        hilo_we_s  = 1'b0;
      end
    endcase
  end

  // Saturating stalled-cycle counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_s && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule
